// File: rtl/bitfusion_pkg.sv
// Shared definitions for the bitfusion partial-sum datapath.
// Default widths and the accumulator FSM state encoding.
package bitfusion_pkg;

    localparam int BF_PSUM_W = 8;
    localparam int BF_ACC_W  = 16;
    localparam int BF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } bf_state_t;

endpackage

// File: rtl/psum_ext_add.sv
// Sign/zero-extends a partial product to the accumulator width and adds it.
// The overflow flag follows the operand interpretation selected by is_signed.
module psum_ext_add #(
    parameter int PSUM_W = bitfusion_pkg::BF_PSUM_W,
    parameter int ACC_W  = bitfusion_pkg::BF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PSUM_W-1:0] psum,
    input  logic              is_signed,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] ext;
    logic             carry_out;
    logic             carry_into_msb;

    always_comb begin
        if (is_signed)
            ext = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};
        else
            ext = {{(ACC_W-PSUM_W){1'b0}}, psum};
        {carry_out, sum} = {1'b0, acc} + {1'b0, ext};
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        carry_into_msb = sum[ACC_W-1] ^ acc[ACC_W-1] ^ ext[ACC_W-1];
        ovf = is_signed ? (carry_into_msb ^ carry_out) : carry_out;
    end

endmodule

// File: rtl/bitfusion_psum_accum.sv
// Accumulates a programmable window of partial products into a wide sum and
// hands the result downstream over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for the first psum of a window
// ACCUM | window open, summing psums with the latched signedness
// HOLD  | result presented on acc_out/acc_ovf until acc_ready
module bitfusion_psum_accum
    import bitfusion_pkg::*;
#(
    parameter int PSUM_W = BF_PSUM_W,
    parameter int ACC_W  = BF_ACC_W,
    parameter int CNT_W  = BF_CNT_W
) (
    input  logic              CLK_125MHZ_FPGA,
    input  logic              rst_n,
    input  logic [PSUM_W-1:0] psum,
    input  logic              s_psum,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [CNT_W-1:0]  acc_len,
    input  logic              clr,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_ovf,
    output logic              acc_valid,
    input  logic              acc_ready
);

    bf_state_t        state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_lat;
    logic             s_lat;

    logic             in_hold;
    logic             accept;
    logic             start;
    logic [ACC_W-1:0] add_a;
    logic             add_signed;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] len_in;
    logic [CNT_W-1:0] cnt_nxt;

    // In HOLD, psum_ready is a combinational copy of acc_ready so a new window
    // can open in the same cycle the result is consumed.
    always_comb begin
        in_hold    = (state == HOLD);
        psum_ready = rst_n & (in_hold ? acc_ready : ~clr);
        accept     = psum_valid & psum_ready;
        start      = accept & ((state == IDLE) | in_hold);
        add_a      = start ? '0 : acc_out;
        add_signed = start ? s_psum : s_lat;
        len_in     = (acc_len == '0) ? CNT_W'(1) : acc_len;
        cnt_nxt    = count + CNT_W'(1);
    end

    psum_ext_add #(
        .PSUM_W (PSUM_W),
        .ACC_W  (ACC_W)
    ) u_ext_add (
        .acc       (add_a),
        .psum      (psum),
        .is_signed (add_signed),
        .sum       (add_sum),
        .ovf       (add_ovf)
    );

    always_ff @(posedge CLK_125MHZ_FPGA or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            acc_valid <= 1'b0;
            count     <= '0;
            len_lat   <= '0;
            s_lat     <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (state == IDLE && clr) begin
                        acc_out <= '0;
                        acc_ovf <= 1'b0;
                        count   <= '0;
                    end else if (start) begin
                        acc_out <= add_sum;
                        acc_ovf <= 1'b0;
                        count   <= CNT_W'(1);
                        len_lat <= len_in;
                        s_lat   <= s_psum;
                        if (len_in == CNT_W'(1)) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end else begin
                            state     <= ACCUM;
                            acc_valid <= 1'b0;
                        end
                    end else if (state == HOLD && acc_ready) begin
                        state     <= IDLE;
                        acc_valid <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (clr) begin
                        state   <= IDLE;
                        acc_out <= '0;
                        acc_ovf <= 1'b0;
                        count   <= '0;
                    end else if (accept) begin
                        acc_out <= add_sum;
                        acc_ovf <= acc_ovf | add_ovf;
                        count   <= cnt_nxt;
                        if (cnt_nxt == len_lat) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
